// File: rtl/eth_header_inserter.sv
// eth_header_inserter: prepends a 14-byte Ethernet header (dst, src, length)
// to a 32-bit payload stream and realigns the payload by 16 bits.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   i_stream/i_valid  payload words in, i_ready back-pressure, i_last end
//   destination_addr  destination MAC, sampled when a packet starts
//   packet_length     payload length in words, sampled with the MAC
//   o_stream/o_valid  framed words out, o_ready from downstream
//   o_last/o_half     final beat of a frame, upper 16 bits only valid
module eth_header_inserter #(
  parameter int unsigned stream_w = 32,
  parameter logic [47:0] src_mac  = 48'h020000000001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [stream_w-1:0] i_stream,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic                i_last,
  input  logic [47:0]         destination_addr,
  input  logic [31:0]         packet_length,
  output logic [stream_w-1:0] o_stream,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_last,
  output logic                o_half
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR0    = 3'd1,
    HDR1    = 3'd2,
    HDR2    = 3'd3,
    PAYLOAD = 3'd4,
    TAIL    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [47:0] dst_q, dst_d;
  logic [13:0] len_q, len_d;
  logic [15:0] hold_q, hold_d;

  // The length field is 16 bits of bytes, so only the low 14 word bits
  // survive the x4 scaling.
  logic unused_len;
  assign unused_len = ^packet_length[31:14];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dst_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    len_d    = len_q;
    hold_d   = hold_q;
    o_stream = '0;
    o_valid  = 1'b0;
    o_last   = 1'b0;
    o_half   = 1'b0;
    i_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Start of packet is seen but the first word is left in place.
        if (i_valid) begin
          dst_d   = destination_addr;
          len_d   = packet_length[13:0];
          state_d = HDR0;
        end
      end
      HDR0: begin
        o_valid  = 1'b1;
        o_stream = dst_q[47:16];
        if (o_ready) state_d = HDR1;
      end
      HDR1: begin
        o_valid  = 1'b1;
        o_stream = {dst_q[15:0], src_mac[47:32]};
        if (o_ready) state_d = HDR2;
      end
      HDR2: begin
        o_valid  = 1'b1;
        o_stream = src_mac[31:0];
        if (o_ready) begin
          hold_d  = {len_q, 2'b00};
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Pass-through handshake: the low half of each word waits one beat.
        o_valid  = i_valid;
        i_ready  = o_ready;
        o_stream = {hold_q, i_stream[31:16]};
        if (i_valid && o_ready) begin
          hold_d = i_stream[15:0];
          if (i_last) state_d = TAIL;
        end
      end
      TAIL: begin
        o_valid  = 1'b1;
        o_last   = 1'b1;
        o_half   = 1'b1;
        o_stream = {hold_q, 16'h0000};
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_header_inserter.sv
// tb_eth_header_inserter: directed bench for eth_header_inserter.
// Beats are collected by a monitor; each test task checks its own results.
module tb_eth_header_inserter;

  logic        clk;
  logic        rst;
  logic [31:0] i_stream;
  logic        i_valid;
  logic        i_ready;
  logic        i_last;
  logic [47:0] destination_addr;
  logic [31:0] packet_length;
  logic [31:0] o_stream;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;
  logic        o_half;

  eth_header_inserter dut (
    .clk              (clk),
    .rst              (rst),
    .i_stream         (i_stream),
    .i_valid          (i_valid),
    .i_ready          (i_ready),
    .i_last           (i_last),
    .destination_addr (destination_addr),
    .packet_length    (packet_length),
    .o_stream         (o_stream),
    .o_valid          (o_valid),
    .o_ready          (o_ready),
    .o_last           (o_last),
    .o_half           (o_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] beats[$];
  int          beat_cyc[$];
  int          ncyc = 0;
  int          stall_cnt = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] p_data;
  logic        p_last;
  logic        p_half;

  // Handshakes and stall stability, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cnt = stall_cnt + 1;
        if (!o_valid || o_stream !== p_data ||
            o_last !== p_last || o_half !== p_half)
          stall_err = stall_err + 1;
      end
      if (o_valid && o_ready) begin
        beats.push_back({o_last, o_half, o_stream});
        beat_cyc.push_back(ncyc);
      end
      prev_stall = o_valid && !o_ready;
      p_data = o_stream;
      p_last = o_last;
      p_half = o_half;
    end
  end

  logic [31:0] pay[8];
  logic        timed_out;
  int          gap_seen = 0;
  int          gap_ovalid = 0;

  // Drives one packet from pay[], starting just after a rising edge.
  task automatic drive_pkt(input logic [47:0] dst, input logic [31:0] len,
                           input int n, input int gap, input bit tog);
    int idx;
    int gapcnt;
    int cyc;
    bit done;
    idx = 0;
    gapcnt = 0;
    cyc = 0;
    done = 0;
    destination_addr = dst;
    packet_length = len;
    while (!done && cyc < 200) begin
      o_ready = tog ? (cyc % 2 == 0) : 1'b1;
      if (idx < n && gapcnt == 0) begin
        i_valid = 1'b1;
        i_stream = pay[idx];
        i_last = (idx == n - 1);
      end else begin
        i_valid = 1'b0;
        i_last = 1'b0;
      end
      @(negedge clk);
      if (i_valid && i_ready) begin
        idx = idx + 1;
        if (idx < n) gapcnt = gap;
      end else if (gapcnt > 0) begin
        gap_seen = gap_seen + 1;
        if (o_valid) gap_ovalid = gap_ovalid + 1;
        gapcnt = gapcnt - 1;
      end
      if (o_valid && o_ready && o_last) done = 1;
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    o_ready = 1'b1;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_valid = 1'b1;
    i_stream = 32'h0;
    destination_addr = 48'hDEADBEEF0123;
    packet_length = 32'd1;
    o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_o_valid: got %b want 0", o_valid);
    end
    n_cmp++;
    if (i_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_i_ready: got %b want 0", i_ready);
    end
    n_cmp++;
    if (o_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_o_last: got %b want 0", o_last);
    end
    n_cmp++;
    if (o_half !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_o_half: got %b want 0", o_half);
    end
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_valid !== 1'b1 || o_stream !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL first_edge_hdr0: got v=%b %h want v=1 deadbeef",
               o_valid, o_stream);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got o_valid=%b want 0", o_valid);
    end
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [33:0] exp[5];
    int base;
    exp[0] = {2'b00, 32'h11223344};
    exp[1] = {2'b00, 32'h55660200};
    exp[2] = {2'b00, 32'h00000001};
    exp[3] = {2'b00, 32'h0004AABB};
    exp[4] = {2'b11, 32'hCCDD0000};
    pay[0] = 32'hAABBCCDD;
    base = beats.size();
    drive_pkt(48'h112233445566, 32'd1, 1, 0, 1'b0);
    n_cmp++;
    if (timed_out || beats.size() - base != 5) begin
      n_bad++;
      $display("FAIL basic_count: got %0d beats to %b want 5",
               beats.size() - base, timed_out);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (beats[base + i] !== exp[i]) begin
        n_bad++;
        $display("FAIL basic_beat%0d: got %h want %h",
                 i, beats[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_stall_gap(input bit tog, input int gap);
    logic [33:0] exp[7];
    int base;
    int s_cnt;
    int s_err;
    int g_seen;
    int g_ov;
    exp[0] = {2'b00, 32'hA0B0C0D0};
    exp[1] = {2'b00, 32'hE0F00200};
    exp[2] = {2'b00, 32'h00000001};
    exp[3] = {2'b00, 32'h000C0102};
    exp[4] = {2'b00, 32'h03040506};
    exp[5] = {2'b00, 32'h0708090A};
    exp[6] = {2'b11, 32'h0B0C0000};
    pay[0] = 32'h01020304;
    pay[1] = 32'h05060708;
    pay[2] = 32'h090A0B0C;
    base = beats.size();
    s_cnt = stall_cnt;
    s_err = stall_err;
    g_seen = gap_seen;
    g_ov = gap_ovalid;
    drive_pkt(48'hA0B0C0D0E0F0, 32'd3, 3, gap, tog);
    n_cmp++;
    if (timed_out || beats.size() - base != 7) begin
      n_bad++;
      $display("FAIL sg%0d_count: got %0d beats to %b want 7",
               gap, beats.size() - base, timed_out);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (beats[base + i] !== exp[i]) begin
        n_bad++;
        $display("FAIL sg%0d_beat%0d: got %h want %h",
                 gap, i, beats[base + i], exp[i]);
      end
    end
    if (tog) begin
      n_cmp++;
      if (stall_cnt - s_cnt < 6 || stall_err != s_err) begin
        n_bad++;
        $display("FAIL stall_stable: got %0d unstable of %0d want 0 of >=6",
                 stall_err - s_err, stall_cnt - s_cnt);
      end
    end else begin
      n_cmp++;
      if (gap_seen - g_seen != 2 * gap || gap_ovalid != g_ov) begin
        n_bad++;
        $display("FAIL gap_ovalid: got %0d valid of %0d want 0 of %0d",
                 gap_ovalid - g_ov, gap_seen - g_seen, 2 * gap);
      end
    end
  endtask

  task automatic test_len_wrap();
    int base;
    pay[0] = 32'h12345678;
    base = beats.size();
    drive_pkt(48'h0000AAAA0000, 32'h00004001, 1, 0, 1'b0);
    n_cmp++;
    if (beats[base + 3] !== {2'b00, 32'h00041234}) begin
      n_bad++;
      $display("FAIL len_wrap: got %h want 000041234", beats[base + 3]);
    end
    n_cmp++;
    if (beats[base + 4] !== {2'b11, 32'h56780000}) begin
      n_bad++;
      $display("FAIL len_wrap_tail: got %h want 356780000", beats[base + 4]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int idx;
    int cyc;
    bit aborted;
    pay[0] = 32'h01020304;
    pay[1] = 32'h05060708;
    pay[2] = 32'h090A0B0C;
    base = beats.size();
    destination_addr = 48'h0A0B0C0D0E0F;
    packet_length = 32'd3;
    o_ready = 1'b1;
    idx = 0;
    cyc = 0;
    aborted = 0;
    while (!aborted && cyc < 30) begin
      i_valid = 1'b1;
      i_stream = pay[idx];
      i_last = (idx == 2);
      if (idx == 1) begin
        #1;
        n_cmp++;
        if (i_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL mid_pre: got i_ready=%b want 1", i_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || i_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL mid_async: got v=%b l=%b r=%b want 0 0 0",
                   o_valid, o_last, i_ready);
        end
        aborted = 1;
      end else begin
        @(negedge clk);
        if (i_valid && i_ready) idx = idx + 1;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
      end
    end
    n_cmp++;
    if (!aborted || beats.size() - base != 4 ||
        beats[base + 3] !== {2'b00, 32'h000C0102}) begin
      n_bad++;
      $display("FAIL mid_partial: got %0d beats ab=%b want 4 no last",
               beats.size() - base, aborted);
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [33:0] exp[11];
    int base;
    int idx;
    int cyc;
    int nlast;
    w[0] = 32'h11111111;
    w[1] = 32'hAAAA5555;
    w[2] = 32'hBBBB6666;
    exp[0]  = {2'b00, 32'h0A0B0C0D};
    exp[1]  = {2'b00, 32'h0E0F0200};
    exp[2]  = {2'b00, 32'h00000001};
    exp[3]  = {2'b00, 32'h00041111};
    exp[4]  = {2'b11, 32'h11110000};
    exp[5]  = {2'b00, 32'h66554433};
    exp[6]  = {2'b00, 32'h22110200};
    exp[7]  = {2'b00, 32'h00000001};
    exp[8]  = {2'b00, 32'h0008AAAA};
    exp[9]  = {2'b00, 32'h5555BBBB};
    exp[10] = {2'b11, 32'h66660000};
    base = beats.size();
    o_ready = 1'b1;
    idx = 0;
    cyc = 0;
    nlast = 0;
    while (nlast < 2 && cyc < 60) begin
      if (idx < 3) begin
        i_valid = 1'b1;
        i_stream = w[idx];
        i_last = (idx != 1);
        destination_addr = (idx == 0) ? 48'h0A0B0C0D0E0F : 48'h665544332211;
        packet_length = (idx == 0) ? 32'd1 : 32'd2;
      end else begin
        i_valid = 1'b0;
        i_last = 1'b0;
      end
      @(negedge clk);
      if (i_valid && i_ready) idx = idx + 1;
      if (o_valid && o_ready && o_last) nlast = nlast + 1;
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    n_cmp++;
    if (nlast != 2 || beats.size() - base != 11) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d beats %0d frames want 11 2",
               beats.size() - base, nlast);
    end
    n_cmp++;
    if (beat_cyc[base + 5] - beat_cyc[base + 4] != 2) begin
      n_bad++;
      $display("FAIL b2b_gap: got %0d cycles want 2",
               beat_cyc[base + 5] - beat_cyc[base + 4]);
    end
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (beats[base + i] !== exp[i]) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got %h want %h",
                 i, beats[base + i], exp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_stream = '0;
    o_ready = 1'b1;
    destination_addr = '0;
    packet_length = '0;
    timed_out = 1'b0;
    test_reset();
    test_basic();
    test_stall_gap(1'b1, 0);
    test_len_wrap();
    test_stall_gap(1'b0, 3);
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_header_inserter.md
ETH_HEADER_INSERTER -- requirements
Module: eth_header_inserter

Interface
REQ-001 Parameter: stream_w, 32, data width; 32 is the only supported value.
REQ-002 Parameter: src_mac, 48'h020000000001, source MAC placed in every header.
REQ-003 clk  in  1  single clock; all flops on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_stream  in  32  payload word from the packet store stage.
REQ-006 i_valid  in  1  payload word valid.
REQ-007 i_ready  out  1  payload word accepted when i_valid && i_ready.
REQ-008 i_last  in  1  marks the final payload word.
REQ-009 destination_addr  in  48  destination MAC; stable from first i_valid of a packet to its i_last handshake.
REQ-010 packet_length  in  32  payload length in words; same stability rule as destination_addr.
REQ-011 o_stream  out  32  framed output word.
REQ-012 o_valid  out  1  output word valid.
REQ-013 o_ready  in  1  downstream accepts when o_valid && o_ready.
REQ-014 o_last  out  1  final beat of the frame.
REQ-015 o_half  out  1  only o_stream[31:16] meaningful on this beat.

Function
REQ-016 The block SHALL prepend a 14-byte Ethernet header (dst MAC, src MAC, 16-bit length field) and realign payload by 16 bits.
REQ-017 States SHALL be IDLE, HDR0, HDR1, HDR2, PAYLOAD, TAIL.
REQ-018 IDLE: o_valid=0, i_ready=0; on i_valid=1 latch destination_addr, packet_length, go to HDR0 next cycle (no input word consumed).
REQ-019 HDR0: o_stream=dst[47:16]; on output handshake -> HDR1.
REQ-020 HDR1: o_stream={dst[15:0], src_mac[47:32]}; on handshake -> HDR2.
REQ-021 HDR2: o_stream=src_mac[31:0]; on handshake load hold[15:0]={packet_length[13:0],2'b00} (byte count, upper bits discarded), -> PAYLOAD.
REQ-022 PAYLOAD: o_stream={hold, i_stream[31:16]}, o_valid=i_valid, i_ready=o_ready (combinational); on handshake hold<=i_stream[15:0]; handshake with i_last -> TAIL.
REQ-023 TAIL: o_stream={hold,16'h0000}, o_valid=1, o_last=1, o_half=1, i_ready=0; on handshake -> IDLE.
REQ-024 o_last and o_half SHALL be 1 only in TAIL; every frame has N+4 beats for N payload words.
REQ-025 i_ready SHALL be 0 in every state except PAYLOAD.
REQ-026 While o_valid=1 and o_ready=0, o_stream/o_last/o_half SHALL hold stable; no word dropped or duplicated.
REQ-027 i_valid gaps in PAYLOAD SHALL drop o_valid with no bubble beat emitted.
REQ-028 Back-to-back packets: a next packet's HDR0 SHALL appear no earlier than 1 cycle after TAIL handshake.
REQ-029 packet_length and i_last disagreement: i_last governs framing; length field is taken from packet_length unchanged.
REQ-030 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, o_valid=0, o_last=0, o_half=0, i_ready=0, hold=0, latched address/length=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no o_last; the next packet after release SHALL frame correctly.
REQ-033 First IDLE detection of i_valid SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-034 dst=48'h112233445566, packet_length=1, payload 32'hAABBCCDD, o_ready=1 -> 32'h11223344, 32'h55660200, 32'h00000001, 32'h0004AABB, 32'hCCDD0000 (o_last=o_half=1).
REQ-035 3-word payload 32'h01020304/05060708/090A0B0C, o_ready toggling each cycle -> 7 beats, payload beats 32'h000C0102, 32'h03040506, 32'h0708090A, tail 32'h0B0C0000; outputs stable while stalled.
REQ-036 packet_length=32'h00004001 -> length field 16'h0004.
REQ-037 i_valid low 3 cycles between payload words -> o_valid low for those cycles, beat sequence identical to gap-free case.
REQ-038 rst=0 during PAYLOAD word 2 -> o_valid=0 asynchronously, no o_last; subsequent 1-word packet matches REQ-034 pattern.
REQ-039 Two consecutive packets with i_valid held high -> second HDR0 beat one cycle after first TAIL handshake, correct second dst.
